// File: rtl/prog_loader.sv
// Framed byte-stream loader: assembles little-endian words from a valid/ready
// byte stream and writes them to instruction or data memory, holding the core in reset.
module prog_loader #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 1024
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_ready,
  output logic              o_imem_we,
  output logic              o_dmem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_cpu_hold,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  // state     | meaning
  // S_IDLE    | waiting for a command byte
  // S_ADDR_LO | expecting start address low byte
  // S_ADDR_HI | expecting start address high byte (range checked)
  // S_CNT_LO  | expecting word count low byte
  // S_CNT_HI  | expecting word count high byte
  // S_DATA    | collecting the 4 bytes of a word
  // S_WRITE   | one-cycle memory write strobe
  // S_DONE    | one-cycle completion pulse
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_LO, S_ADDR_HI, S_CNT_LO, S_CNT_HI, S_DATA, S_WRITE, S_DONE
  } state_t;

  localparam int TW = $clog2(TIMEOUT);

  state_t            r_state;
  state_t            w_next;
  logic              r_sel_d;
  logic [7:0]        r_lo;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_cnt;
  logic [1:0]        r_idx;
  logic [31:0]       r_word;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic [TW-1:0]     r_idle;
  logic              r_err;

  logic        w_ready_st;
  logic        w_accept;
  logic        w_cmd_ok;
  logic [15:0] w_hi_lo;
  logic        w_addr_bad;
  logic        w_counting;
  logic        w_timeout;

  assign w_ready_st = (r_state != S_WRITE) && (r_state != S_DONE);
  assign o_rx_ready = w_ready_st && !i_reset;
  assign w_accept   = i_rx_valid && o_rx_ready;
  assign w_cmd_ok   = (i_rx_data == 8'hA1) || (i_rx_data == 8'hA2);
  assign w_hi_lo    = {i_rx_data, r_lo};
  assign w_addr_bad = (w_hi_lo >> ADDR_W) != 16'd0;
  assign w_counting = r_state inside {S_ADDR_LO, S_ADDR_HI, S_CNT_LO, S_CNT_HI, S_DATA};
  assign w_timeout  = w_counting && !w_accept && (r_idle == '0);

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    o_imem_we = 1'b0;
    o_dmem_we = 1'b0;
    o_done    = 1'b0;
    o_busy    = (r_state != S_IDLE);
    unique case (r_state)
      S_IDLE:    if (w_accept && w_cmd_ok) w_next = S_ADDR_LO;
      S_ADDR_LO: if (w_accept) w_next = S_ADDR_HI;
      S_ADDR_HI: if (w_accept) w_next = w_addr_bad ? S_IDLE : S_CNT_LO;
      S_CNT_LO:  if (w_accept) w_next = S_CNT_HI;
      S_CNT_HI:  if (w_accept) w_next = (w_hi_lo == 16'd0) ? S_DONE : S_DATA;
      S_DATA:    if (w_accept && r_idx == 2'd3) w_next = S_WRITE;
      S_WRITE: begin
        o_imem_we = !r_sel_d;
        o_dmem_we = r_sel_d;
        w_next    = (r_cnt == 16'd1) ? S_DONE : S_DATA;
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_timeout) w_next = S_IDLE;
  end

  assign o_cpu_hold  = o_busy;
  assign o_err       = r_err;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sel_d     <= 1'b0;
      r_lo        <= '0;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_word      <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_idle      <= TW'(TIMEOUT - 1);
      r_err       <= 1'b0;
    end else begin
      // Idle timer reloads on any accepted byte and runs down only inside a frame.
      if (w_accept)
        r_idle <= TW'(TIMEOUT - 1);
      else if (w_counting && r_idle != '0)
        r_idle <= r_idle - 1'b1;
      if (w_timeout) r_err <= 1'b1;

      unique case (r_state)
        S_IDLE: if (w_accept) begin
          if (w_cmd_ok) begin
            r_err   <= 1'b0;
            r_sel_d <= (i_rx_data == 8'hA2);
          end else begin
            r_err <= 1'b1;
          end
        end
        S_ADDR_LO: if (w_accept) r_lo <= i_rx_data;
        S_ADDR_HI: if (w_accept) begin
          if (w_addr_bad) r_err <= 1'b1;
          else            r_addr <= ADDR_W'(w_hi_lo);
        end
        S_CNT_LO: if (w_accept) r_lo <= i_rx_data;
        S_CNT_HI: if (w_accept) begin
          r_cnt <= w_hi_lo;
          r_idx <= 2'd0;
        end
        S_DATA: if (w_accept) begin
          r_word[{r_idx, 3'b000} +: 8] <= i_rx_data;
          r_idx <= r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            r_mem_wdata <= {i_rx_data, r_word[23:0]};
            r_mem_addr  <= r_addr;
          end
        end
        S_WRITE: begin
          r_addr <= r_addr + 1'b1;
          r_cnt  <= r_cnt - 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed and random frames compared against a
// frame-level reference model of the expected memory writes.
module tb_prog_loader;
  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 1024;

  typedef logic [7:0] bq_t[$];
  typedef logic [ADDR_W+32:0] wr_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              rx_ready, imem_we, dmem_we, cpu_hold, busy, done, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  int   n_assert = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  int   both_cnt = 0;
  wr_t  obs_q[$];
  wr_t  exp_q[$];
  logic exp_err;
  int   exp_done;

  always #5 clk = ~clk;

  prog_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_reset(reset), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_rx_ready(rx_ready), .o_imem_we(imem_we), .o_dmem_we(dmem_we),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_cpu_hold(cpu_hold),
    .o_busy(busy), .o_done(done), .o_err(err)
  );

  always @(negedge clk) begin
    if (imem_we && dmem_we) both_cnt++;
    if (imem_we || dmem_we) obs_q.push_back({dmem_we, mem_addr, mem_wdata});
    if (done) done_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: expected writes derived directly from the frame bytes.
  function automatic void model(input bq_t fr);
    int unsigned a, c, ai, k;
    exp_q.delete();
    exp_err  = 1'b0;
    exp_done = 0;
    if (fr[0] != 8'hA1 && fr[0] != 8'hA2) begin
      exp_err = 1'b1;
      return;
    end
    a = {16'h0, fr[2], fr[1]};
    if (a >= (32'd1 << ADDR_W)) begin
      exp_err = 1'b1;
      return;
    end
    c = {16'h0, fr[4], fr[3]};
    for (int unsigned i = 0; i < c; i++) begin
      k  = 5 + 4 * i;
      ai = (a + i) % (32'd1 << ADDR_W);
      exp_q.push_back({fr[0] == 8'hA2, ai[ADDR_W-1:0], fr[k+3], fr[k+2], fr[k+1], fr[k]});
    end
    exp_done = 1;
  endfunction

  function automatic bq_t build(input logic [7:0] cmd, input int addr, input int cnt);
    bq_t q;
    q.push_back(cmd);
    q.push_back(addr[7:0]);
    q.push_back(addr[15:8]);
    q.push_back(cnt[7:0]);
    q.push_back(cnt[15:8]);
    for (int i = 0; i < 4 * cnt; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int g = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) check("rx_ready wait", {63'b0, rx_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_seq(input bq_t fr, input int lo, input int hi, input int gmax);
    for (int i = lo; i < hi; i++) begin
      send_byte(fr[i]);
      if (gmax > 0) repeat ($urandom_range(0, gmax)) @(negedge clk);
    end
  endtask

  task automatic begin_frame(input bq_t fr);
    obs_q.delete();
    done_cnt = 0;
    model(fr);
  endtask

  task automatic finish_frame(input string tag);
    int g = 0;
    while (busy && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check({tag, " settle"}, {63'b0, busy}, 64'd0);
    @(negedge clk);
    check({tag, " nwrites"}, obs_q.size(), exp_q.size());
    foreach (exp_q[i])
      if (i < obs_q.size()) check($sformatf("%s wr%0d", tag, i), obs_q[i], exp_q[i]);
    check({tag, " err"}, {63'b0, err}, {63'b0, exp_err});
    check({tag, " done"}, done_cnt, exp_done);
    check({tag, " hold"}, {63'b0, cpu_hold}, 64'd0);
    check({tag, " we excl"}, both_cnt, 64'd0);
  endtask

  task automatic run_frame(input bq_t fr, input int gmax, input string tag);
    begin_frame(fr);
    send_seq(fr, 0, fr.size(), gmax);
    finish_frame(tag);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " ready"}, {63'b0, rx_ready}, 64'd0);
    check({tag, " busy"}, {63'b0, busy}, 64'd0);
    check({tag, " hold"}, {63'b0, cpu_hold}, 64'd0);
    check({tag, " done"}, {63'b0, done}, 64'd0);
    check({tag, " err"}, {63'b0, err}, 64'd0);
    check({tag, " we"}, {62'b0, imem_we, dmem_we}, 64'd0);
    check({tag, " addr"}, mem_addr, 64'd0);
    check({tag, " wdata"}, mem_wdata, 64'd0);
  endtask

  initial begin
    bq_t fr;
    int  g;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);
    check("ready after reset", {63'b0, rx_ready}, 64'd1);

    // imem load with write-latency checks on the first word
    fr = '{8'hA1, 8'h04, 8'h00, 8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00,
           8'h93, 8'h00, 8'hA0, 8'h00};
    begin_frame(fr);
    send_seq(fr, 0, 9, 0);
    check("w0 imem_we", {63'b0, imem_we}, 64'd1);
    check("w0 dmem_we", {63'b0, dmem_we}, 64'd0);
    check("w0 ready", {63'b0, rx_ready}, 64'd0);
    check("w0 addr", mem_addr, 64'd4);
    check("w0 data", mem_wdata, 64'h0050_0013);
    check("w0 hold", {63'b0, cpu_hold}, 64'd1);
    @(negedge clk);
    check("w0+1 imem_we", {63'b0, imem_we}, 64'd0);
    check("w0+1 ready", {63'b0, rx_ready}, 64'd1);
    check("w0+1 addr hold", mem_addr, 64'd4);
    send_seq(fr, 9, 13, 0);
    finish_frame("imem");
    check("imem last data", mem_wdata, 64'h00A0_0093);

    // zero count
    fr = '{8'hA2, 8'h10, 8'h00, 8'h00, 8'h00};
    begin_frame(fr);
    send_seq(fr, 0, 5, 0);
    check("zero done", {63'b0, done}, 64'd1);
    check("zero hold", {63'b0, cpu_hold}, 64'd1);
    @(negedge clk);
    check("zero done after", {63'b0, done}, 64'd0);
    check("zero hold after", {63'b0, cpu_hold}, 64'd0);
    finish_frame("zero");

    // bad command byte, then a good frame clears err
    fr = '{8'h55};
    begin_frame(fr);
    send_seq(fr, 0, 1, 0);
    check("badcmd err", {63'b0, err}, 64'd1);
    check("badcmd busy", {63'b0, busy}, 64'd0);
    finish_frame("badcmd");
    fr = build(8'hA1, 32'h20, 2);
    begin_frame(fr);
    send_seq(fr, 0, 1, 0);
    check("cmd clears err", {63'b0, err}, 64'd0);
    send_seq(fr, 1, fr.size(), 2);
    finish_frame("after badcmd");

    // address out of range
    fr = '{8'hA1, 8'h00, 8'h04};
    begin_frame(fr);
    send_seq(fr, 0, 3, 0);
    check("badaddr err", {63'b0, err}, 64'd1);
    check("badaddr busy", {63'b0, busy}, 64'd0);
    finish_frame("badaddr");

    // address wrap
    run_frame(build(8'hA2, 32'h3FF, 2), 0, "wrap");

    // inter-byte timeout with a partial word
    fr = build(8'hA1, 32'h0, 1);
    obs_q.delete();
    done_cnt = 0;
    send_seq(fr, 0, 7, 0);
    repeat (TIMEOUT - 2) @(negedge clk);
    check("tmo early err", {63'b0, err}, 64'd0);
    check("tmo early hold", {63'b0, cpu_hold}, 64'd1);
    g = 0;
    while (!err && g < 10) begin
      @(negedge clk);
      g++;
    end
    check("tmo err", {63'b0, err}, 64'd1);
    check("tmo hold", {63'b0, cpu_hold}, 64'd0);
    check("tmo busy", {63'b0, busy}, 64'd0);
    check("tmo nwrites", obs_q.size(), 64'd0);
    check("tmo done", done_cnt, 64'd0);
    run_frame(build(8'hA1, 32'h100, 3), 3, "after tmo");

    // reset in the middle of a frame
    fr = build(8'hA2, 32'h040, 3);
    obs_q.delete();
    done_cnt = 0;
    send_seq(fr, 0, 7, 0);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("midreset");
    reset = 1'b0;
    @(negedge clk);
    check("midreset ready", {63'b0, rx_ready}, 64'd1);
    check("midreset nwrites", obs_q.size(), 64'd0);
    run_frame(fr, 0, "post reset");
    run_frame(fr, 5, "post reset gaps");

    // random frames
    for (int n = 0; n < 5; n++) begin
      fr = build(($urandom_range(0, 1) != 0) ? 8'hA2 : 8'hA1,
                 int'($urandom_range(0, (1 << ADDR_W) - 1)),
                 int'($urandom_range(1, 5)));
      run_frame(fr, 3, $sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader: the write-side counterpart to the core's debug read ports. Accepts a framed byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and writes them into the processor's instruction or data memory at consecutive word addresses. It holds the core in reset for the duration of a load. Sits between a host-link receiver (UART or testbench driver) and the `piPro` memory write ports.

## Interface
- `ADDR_W`, 10, word-address width of both memories
- `TIMEOUT`, 1024, max idle cycles between accepted bytes inside a frame before abort (≥2)
- `clk`  in  1  clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `rx_data`  in  8  incoming byte
- `rx_valid`  in  1  `rx_data` valid
- `rx_ready`  out  1  loader can accept; byte transfers when `rx_valid && rx_ready`
- `imem_we`  out  1  instruction-memory write strobe, 1 cycle
- `dmem_we`  out  1  data-memory write strobe, 1 cycle
- `mem_addr`  out  ADDR_W  word address for the strobe
- `mem_wdata`  out  32  word for the strobe
- `cpu_hold`  out  1  high while a frame is in progress; drives core reset
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  1-cycle pulse on successful frame end
- `err`  out  1  sticky error flag; cleared on the next valid command byte or on reset

## Operation
- Frame format: CMD, ADDR_LO, ADDR_HI, CNT_LO, CNT_HI, then CNT×4 data bytes, LSB first per word.
- CMD: 0xA1 selects imem, 0xA2 selects dmem. Any other byte in IDLE is consumed and dropped, sets `err`, and leaves the state at IDLE.
- Start address is 16 bits. Bits above ADDR_W must be 0; otherwise set `err` and go to IDLE after ADDR_HI.
- CNT is a 16-bit word count. CNT=0 is legal and goes straight to DONE after CNT_HI.
- States: IDLE → ADDR_LO → ADDR_HI → CNT_LO → CNT_HI → DATA → WRITE → (DATA | DONE) → IDLE.
- DATA uses a 2-bit byte index. Byte k goes into word bits [8k+7:8k]. Acceptance of byte 3 moves the state to WRITE.
- WRITE lasts one cycle:
  - The selected `*_we` is 1, with `mem_addr` and `mem_wdata` valid.
  - The address increments modulo 2^ADDR_W, so it wraps 2^ADDR_W−1 → 0 with no error.
  - The remaining count decrements.
  - Next state is DONE if the count reaches 0, otherwise DATA.
- DONE lasts one cycle: `done`=1, `cpu_hold`=1. The next cycle is IDLE with `cpu_hold`=0.
- `rx_ready` = 1 in IDLE, ADDR_LO, ADDR_HI, CNT_LO, CNT_HI, and DATA. It is 0 in WRITE and DONE, and 0 while `reset` is high.
- Idle counter:
  - Resets on every accepted byte and on entry to ADDR_LO.
  - Counts only in ADDR_LO..DATA.
  - On reaching TIMEOUT: set `err`, go to IDLE, drop `cpu_hold`, discard any partial word with no write.
- `cpu_hold` rises in the cycle after a valid CMD is accepted. It stays high through DONE or the abort cycle.
- `imem_we` and `dmem_we` are never high together.

## Timing
- Reset values: state IDLE, `rx_ready`=0 during reset then 1. `imem_we`, `dmem_we`, `cpu_hold`, `busy`, `done`, `err` = 0. `mem_addr` = 0, `mem_wdata` = 0.
- Reset has priority over all events. Reset mid-frame drops the frame with no further strobes; the next frame starts cleanly.
- Write latency: 4th data byte accepted at edge N → strobe high in cycle N+1 → back in DATA (`rx_ready`=1) in cycle N+2.
- Peak throughput is one word per 5 cycles.
- `rx_valid` may drop between bytes. A gap shorter than TIMEOUT cycles is harmless.
- `mem_addr` and `mem_wdata` hold their last values outside WRITE.

## Test plan
- Load imem: A1 04 00 02 00, then 13 00 50 00 and 93 00 A0 00 → `imem_we` at addr 4 with 0x00500013, then at addr 5 with 0x00A00093. Then `done` pulses once, `cpu_hold` falls, and `dmem_we` stays 0 throughout.
- Zero count: A2 10 00 00 00 → no strobes, `done` one cycle after CNT_HI is accepted, `cpu_hold` high for exactly that frame.
- Bad inputs:
  - Byte 0x55 in IDLE → `err`=1, state IDLE, no strobe. A following valid A1 frame clears `err` and loads normally.
  - A1 00 04 … (addr 0x400) → `err`=1, IDLE.
- Wrap: A2 FF 03 02 00 with 8 data bytes → `dmem_we` at 0x3FF, then at 0x000, no `err`.
- Timeout: A1 00 00 01 00 then 2 data bytes, then silence for 1024 cycles → `err`=1, `cpu_hold`=0, no strobe. A fresh frame afterwards succeeds.
- Reset mid-frame: assert `reset` for 1 cycle after the 2nd data byte of word 1 of a 3-word frame → outputs at reset values, no strobe. A full 3-word frame then writes 3 words correctly. Also run random 0–5 cycle `rx_valid` gaps during this frame to confirm identical results.
